// File: rtl/wb_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl_if
//   Bundles the command, response and Wishbone master signals of
//   wb_master_ctrl.
//     master modport : the controller's view (drives cmd_ready, rsp_*, wbm_*_o)
//     slave  modport : the environment's view (drives cmd_*, rsp_ready,
//                      wbm_ack_i, wbm_dat_i)
//   Signal groups:
//     cmd_valid/cmd_ready/cmd_we/cmd_adr/cmd_dat/cmd_sel  command port
//     rsp_valid/rsp_ready/rsp_dat/rsp_err                 response port
//     wbm_cyc_o/wbm_stb_o/wbm_we_o/wbm_sel_o/wbm_adr_o/
//     wbm_dat_o/wbm_ack_i/wbm_dat_i                        Wishbone classic bus
// -----------------------------------------------------------------------------
interface wb_master_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // command port
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_W-1:0]     cmd_adr;
   logic [DATA_W-1:0]     cmd_dat;
   logic [DATA_W/8-1:0]   cmd_sel;

   // response port
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_dat;
   logic                  rsp_err;

   // Wishbone master side
   logic                  wbm_cyc_o;
   logic                  wbm_stb_o;
   logic                  wbm_we_o;
   logic [DATA_W/8-1:0]   wbm_sel_o;
   logic [ADDR_W-1:0]     wbm_adr_o;
   logic [DATA_W-1:0]     wbm_dat_o;
   logic                  wbm_ack_i;
   logic [DATA_W-1:0]     wbm_dat_i;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
      output cmd_ready,
      output rsp_valid, rsp_dat, rsp_err,
      input  rsp_ready,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
      input  cmd_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      output rsp_ready,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface

// File: rtl/wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl
//   Wishbone classic single-transfer initiator. Takes one read/write command
//   from the command port, runs one Wishbone cycle, and returns read data
//   (or an error after TIMEOUT unacknowledged strobe cycles) on the response
//   port.
//   Parameters:
//     ADDR_W   address width
//     DATA_W   data width (byte-select width DATA_W/8)
//     TIMEOUT  strobe cycles allowed without ack before abort (1..255)
//   Ports:
//     wb_clk_i  clock, rising edge
//     wb_rst_i  asynchronous active-high reset
//     bus       wb_master_ctrl_if.master (command, response, Wishbone)
// -----------------------------------------------------------------------------
module wb_master_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 31
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_master_ctrl_if.master bus
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Counter value seen during the last permitted strobe cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_RESP
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    to_cnt;

   logic                cyc_q;
   logic                we_q;
   logic [SEL_W-1:0]    sel_q;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   dat_q;

   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_dat_q;
   logic                rsp_err_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         to_cnt      <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  we_q   <= bus.cmd_we;
                  sel_q  <= bus.cmd_sel;
                  adr_q  <= bus.cmd_adr;
                  dat_q  <= bus.cmd_dat;
                  cyc_q  <= 1'b1;
                  to_cnt <= '0;
                  state  <= ST_BUS;
               end
            end

            ST_BUS: begin
               // Ack is checked before the timeout so an ack in the last
               // allowed strobe cycle still completes normally.
               if (bus.wbm_ack_i) begin
                  cyc_q       <= 1'b0;
                  rsp_dat_q   <= we_q ? '0 : bus.wbm_dat_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RESP;
               end else if (to_cnt == CNT_LAST) begin
                  cyc_q       <= 1'b0;
                  rsp_dat_q   <= '1;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
               cyc_q <= 1'b0;
            end
         endcase
      end
   end

   // Strobe and cycle share one register so they can never disagree.
   always_comb begin
      bus.cmd_ready = (state == ST_IDLE);
      bus.wbm_cyc_o = cyc_q;
      bus.wbm_stb_o = cyc_q;
      bus.wbm_we_o  = we_q;
      bus.wbm_sel_o = sel_q;
      bus.wbm_adr_o = adr_q;
      bus.wbm_dat_o = dat_q;
      bus.rsp_valid = rsp_valid_q;
      bus.rsp_dat   = rsp_dat_q;
      bus.rsp_err   = rsp_err_q;
   end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_master_ctrl
//   Self-checking bench for wb_master_ctrl: a table of directed transactions,
//   a reset-during-bus sequence, then randomized transactions whose expected
//   results come from a transaction-level model (strobe length, error flag,
//   response data derived from the slave's ack delay).
// -----------------------------------------------------------------------------
module tb_wb_master_ctrl;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 31;
   localparam int NEVER   = 1000;

   typedef struct {
      logic          we;
      logic [31:0]   adr;
      logic [31:0]   dat;
      logic [3:0]    sel;
      int            delay;      // wait cycles before slave ack (>=TIMEOUT: never)
      logic [31:0]   rdata;      // slave read data
      int            hold;       // cycles rsp_ready is held low after rsp_valid
      logic          spur;       // slave drives ack while no cycle is active
      int            exp_cycles; // strobe cycles == edges from accept to rsp_valid
      logic          exp_err;
      logic [31:0]   exp_dat;
   } vec_t;

   logic clk;
   logic rst;

   wb_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   wb_master_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;

   // slave model controls
   int          ack_delay = NEVER;
   logic [31:0] slv_data  = '0;
   logic        spurious  = 1'b0;
   int          slv_cnt   = 0;
   int          stb_seen  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Slave responder: acks in strobe cycle number ack_delay (0-based),
   // drives random garbage on read data in every other cycle.
   initial begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = '0;
      forever begin
         @(negedge clk);
         if (bus.wbm_cyc_o === 1'b1) begin
            bus.wbm_ack_i = (slv_cnt == ack_delay);
            bus.wbm_dat_i = (slv_cnt == ack_delay) ? slv_data : $urandom;
            slv_cnt++;
            stb_seen++;
         end else begin
            bus.wbm_ack_i = spurious;
            bus.wbm_dat_i = $urandom;
            slv_cnt = 0;
         end
      end
   end

   // Transaction-level reference: a slave that waits d cycles acks in strobe
   // cycle d+1, which only counts if that is within TIMEOUT cycles.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.delay < TIMEOUT) begin
         r.exp_cycles = v.delay + 1;
         r.exp_err    = 1'b0;
         r.exp_dat    = v.we ? 32'h0 : v.rdata;
      end else begin
         r.exp_cycles = TIMEOUT;
         r.exp_err    = 1'b1;
         r.exp_dat    = 32'hFFFF_FFFF;
      end
      return r;
   endfunction

   task automatic run_cmd(input vec_t v);
      int   lat;
      bit   got;
      bit   stable;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      ack_delay     = v.delay;
      slv_data      = v.rdata;
      spurious      = v.spur;
      stb_seen      = 0;
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = v.we;
      bus.cmd_adr   = v.adr;
      bus.cmd_dat   = v.dat;
      bus.cmd_sel   = v.sel;
      @(posedge clk); #1;
      chk("accept_cyc", 32'(bus.wbm_cyc_o), 32'd1);
      chk("accept_stb", 32'(bus.wbm_stb_o), 32'd1);
      chk("accept_we",  32'(bus.wbm_we_o), 32'(v.we));
      chk("accept_adr", bus.wbm_adr_o, v.adr);
      chk("accept_dat", bus.wbm_dat_o, v.dat);
      chk("accept_sel", 32'(bus.wbm_sel_o), 32'(v.sel));
      chk("bus_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      // Scramble command inputs so any late re-latching is visible.
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = ~v.we;
      bus.cmd_adr   = ~v.adr;
      bus.cmd_dat   = ~v.dat;
      bus.cmd_sel   = ~v.sel;
      lat    = 0;
      got    = 0;
      stable = 1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.rsp_valid === 1'b1) begin
            got = 1;
         end else if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 ||
                      bus.wbm_we_o !== v.we || bus.wbm_adr_o !== v.adr ||
                      bus.wbm_dat_o !== v.dat || bus.wbm_sel_o !== v.sel ||
                      bus.cmd_ready !== 1'b0) begin
            stable = 0;
         end
      end
      chk("rsp_seen",    32'(got), 32'd1);
      chk("bus_stable",  32'(stable), 32'd1);
      chk("rsp_latency", 32'(lat), 32'(v.exp_cycles));
      chk("stb_cycles",  32'(stb_seen), 32'(v.exp_cycles));
      chk("end_cyc",     32'(bus.wbm_cyc_o), 32'd0);
      chk("end_stb",     32'(bus.wbm_stb_o), 32'd0);
      chk("rsp_err",     32'(bus.rsp_err), 32'(v.exp_err));
      chk("rsp_dat",     bus.rsp_dat, v.exp_dat);
      chk("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         // A competing command must not be taken while the response waits.
         bus.cmd_valid = 1'b1;
         @(posedge clk); #1;
         chk("hold_valid",     32'(bus.rsp_valid), 32'd1);
         chk("hold_dat",       bus.rsp_dat, v.exp_dat);
         chk("hold_err",       32'(bus.rsp_err), 32'(v.exp_err));
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("hold_cyc",       32'(bus.wbm_cyc_o), 32'd0);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("hs_cyc",       32'(bus.wbm_cyc_o), 32'd0);
   endtask

   vec_t tbl[6];
   vec_t rv;

   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_adr   = '0;
      bus.cmd_dat   = '0;
      bus.cmd_sel   = '0;
      bus.rsp_ready = 1'b0;

      // we, adr, dat, sel, delay, rdata, hold, spur, exp_cycles, exp_err, exp_dat
      tbl[0] = '{1'b1, 32'h3800_0000, 32'h1234_5678, 4'hF, 0,       32'h5555_AAAA, 0, 1'b0, 1,  1'b0, 32'h0000_0000};
      tbl[1] = '{1'b0, 32'h3800_0004, 32'h0000_0000, 4'hF, 10,      32'hCAFE_F00D, 5, 1'b0, 11, 1'b0, 32'hCAFE_F00D};
      tbl[2] = '{1'b0, 32'h3800_0008, 32'h0000_0000, 4'hF, NEVER,   32'h1111_2222, 1, 1'b0, 31, 1'b1, 32'hFFFF_FFFF};
      tbl[3] = '{1'b0, 32'h3800_000C, 32'h0000_0000, 4'hF, 30,      32'hA5A5_0001, 0, 1'b1, 31, 1'b0, 32'hA5A5_0001};
      tbl[4] = '{1'b1, 32'h0000_0010, 32'hDEAD_0001, 4'h3, 31,      32'h7777_7777, 2, 1'b1, 31, 1'b1, 32'hFFFF_FFFF};
      tbl[5] = '{1'b1, 32'h1000_0020, 32'h0BAD_CAFE, 4'h5, 5,       32'h3333_4444, 0, 1'b0, 6,  1'b0, 32'h0000_0000};

      repeat (3) @(negedge clk);
      chk("rst_cyc",       32'(bus.wbm_cyc_o), 32'd0);
      chk("rst_stb",       32'(bus.wbm_stb_o), 32'd0);
      chk("rst_we",        32'(bus.wbm_we_o), 32'd0);
      chk("rst_sel",       32'(bus.wbm_sel_o), 32'd0);
      chk("rst_adr",       bus.wbm_adr_o, 32'd0);
      chk("rst_dat_o",     bus.wbm_dat_o, 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_dat",   bus.rsp_dat, 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      foreach (tbl[i]) run_cmd(tbl[i]);

      // Reset in the middle of a bus cycle to a silent slave.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      ack_delay     = NEVER;
      spurious      = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = 1'b0;
      bus.cmd_adr   = 32'h3800_0040;
      bus.cmd_sel   = 4'hF;
      @(posedge clk); #1;
      chk("mid_rst_cyc_up", 32'(bus.wbm_cyc_o), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cyc_async", 32'(bus.wbm_cyc_o), 32'd0);
      chk("mid_rst_stb_async", 32'(bus.wbm_stb_o), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("after_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         chk("after_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("after_rst_cyc",       32'(bus.wbm_cyc_o), 32'd0);
      end

      for (int n = 0; n < 40; n++) begin
         rv.we    = 1'($urandom_range(0, 1));
         rv.adr   = $urandom;
         rv.dat   = $urandom;
         rv.sel   = 4'($urandom);
         case ($urandom_range(0, 5))
            0:       rv.delay = 0;
            1:       rv.delay = TIMEOUT - 1;
            2:       rv.delay = TIMEOUT;
            3:       rv.delay = NEVER;
            default: rv.delay = int'($urandom_range(0, TIMEOUT + 5));
         endcase
         rv.rdata = $urandom;
         rv.hold  = int'($urandom_range(0, 3));
         rv.spur  = 1'($urandom_range(0, 1));
         run_cmd(model(rv));
      end

      @(negedge clk);
      bus.rsp_ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
